// File: rtl/fma_pkg.sv
// fma_pkg: shared widths and result record for the FMA exponent datapath.
// Width helpers PEW/ACW give the product-exponent and alignment-count widths
// for any exponent field width; the packed records describe one result for
// half precision (NE=5) and for double precision (NE=11).
package fma_pkg;

    localparam int NE_HP = 5;
    localparam int NE_DP = 11;
    localparam int TW_DEF = 4;

    function automatic int PEW(input int ne);
        return ne + 2;
    endfunction

    function automatic int ACW(input int ne);
        return ne + 3;
    endfunction

    typedef struct packed {
        logic signed [PEW(NE_HP)-1:0] pe;
        logic signed [ACW(NE_HP)-1:0] acnt;
        logic                         pzero;
        logic                         zkill;
        logic [TW_DEF-1:0]            tag;
    } fmaexp_t;

    typedef struct packed {
        logic signed [PEW(NE_DP)-1:0] pe;
        logic signed [ACW(NE_DP)-1:0] acnt;
        logic                         pzero;
        logic                         zkill;
        logic [TW_DEF-1:0]            tag;
    } fmaexp_dp_t;

endpackage

// File: rtl/fmaexppipereg.sv
// fmaexppipereg: one elastic pipeline stage holding a valid bit and a payload.
// Ports: clk, reset (async, active high); upstream in_valid/in_ready/in_data;
// downstream out_valid/out_ready/out_data.
// The stage accepts when empty or when its current entry leaves this cycle,
// so in_ready ripples combinationally back through a chain of stages.
module fmaexppipereg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid | out_ready;

    // Payload only loads on an actual transfer, keeping a stalled entry stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/fmaexppipe.sv
// fmaexppipe: pipelined FMA exponent datapath (product exponent + addend alignment count).
// Ports: clk, reset (async, active high); InValid/InReady input handshake;
// Xe/Ye/Ze biased exponents; XZero/YZero/ZZero zero flags; Mul (x*y vs x);
// Add (z participates); InTag passthrough; OutValid/OutReady output handshake;
// Pe product exponent (signed, biased); Acnt = Ze_eff - Pe; PZero; ZKill; OutTag.
// All math is done at the input; the result then rides STAGES elastic stages.
module fmaexppipe
    import fma_pkg::*;
#(
    parameter int NE     = 5,
    parameter int BIAS   = 15,
    parameter int STAGES = 2,
    parameter int TW     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [NE-1:0]        Xe,
    input  logic [NE-1:0]        Ye,
    input  logic [NE-1:0]        Ze,
    input  logic                 XZero,
    input  logic                 YZero,
    input  logic                 ZZero,
    input  logic                 Mul,
    input  logic                 Add,
    input  logic [TW-1:0]        InTag,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [PEW(NE)-1:0]   Pe,
    output logic [ACW(NE)-1:0]   Acnt,
    output logic                 PZero,
    output logic                 ZKill,
    output logic [TW-1:0]        OutTag
);

    localparam int PW = PEW(NE);
    localparam int AW = ACW(NE);
    localparam int DW = PW + AW + 2 + TW;

    logic [NE-1:0] xe_eff, ye_eff, ze_eff;
    logic [PW-1:0] prod, pe;
    logic [AW-1:0] acnt;
    logic          pzero, zkill;

    // Subnormal exponent fields behave as exponent 1.
    assign xe_eff = (Xe == '0) ? NE'(1) : Xe;
    assign ye_eff = (Ye == '0) ? NE'(1) : Ye;
    assign ze_eff = (Ze == '0) ? NE'(1) : Ze;

    // Two guard bits hold both the carry of the sum and the sign after -BIAS.
    assign prod  = PW'(xe_eff) + PW'(ye_eff) - PW'(BIAS);
    assign pzero = XZero | (Mul & YZero);
    assign zkill = !Add | ZZero;
    assign pe    = pzero ? '0 : (Mul ? prod : PW'(xe_eff));
    assign acnt  = (zkill | pzero) ? '0 : AW'(ze_eff) - {{(AW-PW){pe[PW-1]}}, pe};

    logic          valid [STAGES+1];
    logic          ready [STAGES+1];
    logic [DW-1:0] data  [STAGES+1];

    assign valid[0]      = InValid;
    assign data[0]       = {pe, acnt, pzero, zkill, InTag};
    assign ready[STAGES] = OutReady;
    assign InReady       = ready[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        fmaexppipereg #(.DW(DW)) u_reg (
            .clk      (clk),
            .reset    (reset),
            .in_valid (valid[g]),
            .in_ready (ready[g]),
            .in_data  (data[g]),
            .out_valid(valid[g+1]),
            .out_ready(ready[g+1]),
            .out_data (data[g+1])
        );
    end

    assign OutValid = valid[STAGES];
    assign {Pe, Acnt, PZero, ZKill, OutTag} = data[STAGES];

endmodule
